// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM load sequencer.
// Holds the FSM state encoding and parameter defaults.
package sram_ctrl_pkg;

  typedef enum logic [3:0] {
    START_IDLE,
    LOAD_IMAGE,
    WAIT_IMAGE,
    DONE_IMAGE,
    COEF_IDLE,
    LOAD_COEF,
    WAIT_COEF,
    COEF_DONE,
    ERROR
  } state_t;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_CNT_W   = 16;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest requesting index at or above ptr,
// wrapping to index 0 when nothing above ptr requests.
module rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic [NUM_CH-1:0]        req,
  input  logic [sel_w(NUM_CH)-1:0] ptr,
  output logic [sel_w(NUM_CH)-1:0] idx,
  output logic                     valid
);

  localparam int SW = sel_w(NUM_CH);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!valid && req[j] && (j >= int'(ptr))) begin
        valid = 1'b1;
        idx   = SW'(j);
      end
    end
    // second pass covers the wrap below ptr
    for (int j = 0; j < NUM_CH; j++) begin
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = SW'(j);
      end
    end
  end

endmodule

// File: rtl/sram_load_sequencer.sv
// Sequences one image load then round-robin coefficient loads
// through a shared SRAM port, with a WAIT-state timeout.
module sram_load_sequencer
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start_detecting,
  input  logic [NUM_CH-1:0]        request_coef,
  input  logic                     done_processing,
  input  logic                     sram_done,
  input  logic                     clear_err,
  output logic                     start_sram,
  output logic                     n_coef_image,
  output logic [sel_w(NUM_CH)-1:0] coef_sel,
  output logic [NUM_CH-1:0]        coef_grant,
  output logic                     image_weights_loaded,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         load_count
);

  localparam int SW = sel_w(NUM_CH);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   arb_idx;
  logic            arb_valid;
  logic [TW-1:0]   timer;
  logic            in_wait;
  logic            tmo;

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req  (request_coef),
    .ptr  (rr_ptr),
    .idx  (arb_idx),
    .valid(arb_valid)
  );

  assign in_wait = (state == WAIT_IMAGE) || (state == WAIT_COEF);
  // sram_done on the last allowed cycle still completes
  assign tmo = (timer == TW'(TIMEOUT - 1)) && !sram_done;

  always_comb begin
    state_nx             = state;
    start_sram           = 1'b0;
    n_coef_image         = 1'b0;
    coef_grant           = '0;
    image_weights_loaded = 1'b0;
    busy                 = 1'b0;
    timeout_err          = 1'b0;
    unique case (state)
      START_IDLE: begin
        if (start_detecting) state_nx = LOAD_IMAGE;
      end
      LOAD_IMAGE: begin
        start_sram   = 1'b1;
        n_coef_image = 1'b1;
        busy         = 1'b1;
        state_nx     = WAIT_IMAGE;
      end
      WAIT_IMAGE: begin
        n_coef_image = 1'b1;
        busy         = 1'b1;
        if (sram_done) state_nx = DONE_IMAGE;
        else if (tmo)  state_nx = ERROR;
      end
      DONE_IMAGE: begin
        busy                 = 1'b1;
        image_weights_loaded = 1'b1;
        state_nx             = COEF_IDLE;
      end
      COEF_IDLE: begin
        if (arb_valid)            state_nx = LOAD_COEF;
        else if (done_processing) state_nx = START_IDLE;
      end
      LOAD_COEF: begin
        start_sram = 1'b1;
        busy       = 1'b1;
        state_nx   = WAIT_COEF;
      end
      WAIT_COEF: begin
        busy = 1'b1;
        if (sram_done) state_nx = COEF_DONE;
        else if (tmo)  state_nx = ERROR;
      end
      COEF_DONE: begin
        busy                 = 1'b1;
        image_weights_loaded = 1'b1;
        coef_grant           = NUM_CH'(1) << coef_sel;
        state_nx             = COEF_IDLE;
      end
      ERROR: begin
        timeout_err = 1'b1;
        if (clear_err) state_nx = START_IDLE;
      end
      default: state_nx = START_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= START_IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      if ((state == LOAD_IMAGE) || (state == LOAD_COEF))
        timer <= '0;
      else if (in_wait)
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      load_count <= '0;
    end else if ((state == START_IDLE) && start_detecting) begin
      load_count <= '0;
    end else if ((state == DONE_IMAGE) || (state == COEF_DONE)) begin
      if (load_count != '1) load_count <= load_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      coef_sel <= '0;
      rr_ptr   <= '0;
    end else begin
      if ((state == COEF_IDLE) && arb_valid)
        coef_sel <= arb_idx;
      if (state == COEF_DONE)
        rr_ptr <= (coef_sel == SW'(NUM_CH - 1)) ? '0 : coef_sel + 1'b1;
    end
  end

endmodule
